// File: rtl/rs232_tx_fifo.sv
`default_nettype none
// ============================================================================
// Module   : rs232_tx_fifo
// Purpose  : RS232 transmitter with a transmit FIFO, programmable baud
//            divisor and per-frame format (data bits, parity, stop bits).
//            Frames are sent back-to-back with no idle gap while data is
//            queued.
// Ports    : clk, rst (async, active-high)
//            div        - clock cycles per bit (0/1 behave as 2)
//            parity_en  - add a parity bit after the data bits
//            parity_odd - 1 = odd parity, 0 = even parity
//            two_stop   - 1 = two stop bits
//            start/data - one-cycle push strobe and byte to queue
//            ovf_clr    - clears the sticky overflow flag
//            rdy        - FIFO not full
//            idle       - FIFO empty and no frame in progress
//            level      - FIFO occupancy
//            ovf        - sticky: a push was dropped on a full FIFO
//            TxD        - serial line, idles high
// Revision : 1.0 - initial release
// ============================================================================
module rs232_tx_fifo #(
    parameter int DATA_BITS  = 8,
    parameter int FIFO_DEPTH = 16,
    parameter int DIV_W      = 16,
    parameter int LVL_W      = 5
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DIV_W-1:0]     div,
    input  logic                 parity_en,
    input  logic                 parity_odd,
    input  logic                 two_stop,
    input  logic                 start,
    input  logic [DATA_BITS-1:0] data,
    input  logic                 ovf_clr,
    output logic                 rdy,
    output logic                 idle,
    output logic [LVL_W-1:0]     level,
    output logic                 ovf,
    output logic                 TxD
);

    localparam int               c_AW        = $clog2(FIFO_DEPTH);
    localparam logic [LVL_W-1:0] c_FULL      = LVL_W'(FIFO_DEPTH);
    localparam logic [3:0]       c_LAST_DATA = 4'(DATA_BITS - 1);
    localparam logic [DIV_W-1:0] c_DIV_MIN   = DIV_W'(2);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    // FIFO storage and pointers
    logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
    logic [c_AW-1:0]      wr_ptr_q;
    logic [c_AW-1:0]      rd_ptr_q;
    logic [LVL_W-1:0]     level_q;
    logic [LVL_W-1:0]     level_d;
    logic                 ovf_q;
    logic                 ovf_d;

    // Frame engine
    state_t               state_q;
    logic [DIV_W-1:0]     tick_q;
    logic [3:0]           bit_q;
    logic [DATA_BITS-1:0] shreg_q;
    logic                 par_bit_q;
    logic [DIV_W-1:0]     div_l_q;
    logic                 par_en_l_q;
    logic                 two_stop_l_q;
    logic                 txd_q;

    logic                 w_push;
    logic                 w_drop;
    logic                 w_pop;
    logic                 w_bit_end;
    logic                 w_last_stop;
    logic [DIV_W-1:0]     w_div_clamp;
    logic [DATA_BITS-1:0] w_head;

    assign w_head      = mem_q[rd_ptr_q];
    assign w_div_clamp = (div < c_DIV_MIN) ? c_DIV_MIN : div;
    assign w_bit_end   = (tick_q == (div_l_q - DIV_W'(1)));
    // Last stop bit: the only stop bit, or the second one when two are sent.
    assign w_last_stop = (state_q == S_STOP) && w_bit_end &&
                         (!two_stop_l_q || (bit_q == 4'd1));
    assign w_push      = start && (level_q != c_FULL);
    // A full FIFO refuses the push even if a pop frees a slot this cycle.
    assign w_drop      = start && (level_q == c_FULL);
    assign w_pop       = (level_q != '0) && ((state_q == S_IDLE) || w_last_stop);

    assign level_d = level_q + LVL_W'(w_push) - LVL_W'(w_pop);
    // A new drop wins over a simultaneous clear.
    assign ovf_d   = w_drop ? 1'b1 : (ovf_clr ? 1'b0 : ovf_q);

    always_ff @(posedge clk) begin
        if (w_push) begin
            mem_q[wr_ptr_q] <= data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            if (w_push) wr_ptr_q <= wr_ptr_q + c_AW'(1);
            if (w_pop)  rd_ptr_q <= rd_ptr_q + c_AW'(1);
            level_q <= level_d;
            ovf_q   <= ovf_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            tick_q       <= '0;
            bit_q        <= '0;
            shreg_q      <= '0;
            par_bit_q    <= 1'b0;
            div_l_q      <= c_DIV_MIN;
            par_en_l_q   <= 1'b0;
            two_stop_l_q <= 1'b0;
            txd_q        <= 1'b1;
        end else if (w_pop) begin
            // Load the next frame and its format; the start bit goes out now.
            shreg_q      <= w_head;
            par_bit_q    <= (^w_head) ^ parity_odd;
            div_l_q      <= w_div_clamp;
            par_en_l_q   <= parity_en;
            two_stop_l_q <= two_stop;
            tick_q       <= '0;
            bit_q        <= '0;
            state_q      <= S_START;
            txd_q        <= 1'b0;
        end else begin
            if (state_q == S_IDLE) begin
                tick_q <= '0;
            end else begin
                tick_q <= w_bit_end ? '0 : tick_q + DIV_W'(1);
            end
            case (state_q)
                S_START: begin
                    if (w_bit_end) begin
                        state_q <= S_DATA;
                        txd_q   <= shreg_q[0];
                    end
                end
                S_DATA: begin
                    if (w_bit_end) begin
                        if (bit_q == c_LAST_DATA) begin
                            bit_q <= '0;
                            if (par_en_l_q) begin
                                state_q <= S_PARITY;
                                txd_q   <= par_bit_q;
                            end else begin
                                state_q <= S_STOP;
                                txd_q   <= 1'b1;
                            end
                        end else begin
                            bit_q   <= bit_q + 4'd1;
                            shreg_q <= shreg_q >> 1;
                            txd_q   <= shreg_q[1];
                        end
                    end
                end
                S_PARITY: begin
                    if (w_bit_end) begin
                        state_q <= S_STOP;
                        bit_q   <= '0;
                        txd_q   <= 1'b1;
                    end
                end
                S_STOP: begin
                    if (w_bit_end) begin
                        if (w_last_stop) begin
                            state_q <= S_IDLE;
                        end else begin
                            bit_q <= 4'd1;
                        end
                    end
                    txd_q <= 1'b1;
                end
                default: begin
                    txd_q <= 1'b1;
                end
            endcase
        end
    end

    assign rdy   = (level_q != c_FULL);
    assign idle  = (state_q == S_IDLE) && (level_q == '0);
    assign level = level_q;
    assign ovf   = ovf_q;
    assign TxD   = txd_q;

endmodule
`default_nettype wire
